// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_rows_pipe
// Purpose  : Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns,
//            followed by a valid/ready register pipeline of STAGES stages.
//            Optional sideband tag path enabled by SHIFT_ROWS_PIPE_TAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_rows_pipe #(
   parameter int NB     = 4,
   parameter int STAGES = 1,
   parameter int TAG_W  = 8
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_inverse,
   input  logic [0:32*NB-1]  i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [0:32*NB-1]  o_data
`ifdef SHIFT_ROWS_PIPE_TAG_EN
   ,
   input  logic [TAG_W-1:0]  i_tag,
   output logic [TAG_W-1:0]  o_tag
`endif
);

   localparam int c_W = 32 * NB;

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("shift_rows_pipe: NB must be 4, 6 or 8");
      end
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("shift_rows_pipe: STAGES must be in 1..4");
      end
      if (TAG_W < 1) begin : g_bad_tag_w
         $error("shift_rows_pipe: TAG_W must be at least 1");
      end
   endgenerate

   // Byte permutation: every destination byte selects one of two fixed sources.
   logic [0:c_W-1] w_shifted;

   generate
      for (genvar c = 0; c < NB; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int c_S   = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int c_DST = 4 * c + r;
            localparam int c_FWD = 4 * ((c + c_S) % NB) + r;
            localparam int c_INV = 4 * ((c + NB - c_S) % NB) + r;
            assign w_shifted[8*c_DST +: 8] = i_inverse ? i_data[8*c_INV +: 8]
                                                       : i_data[8*c_FWD +: 8];
         end
      end
   endgenerate

   logic [STAGES-1:0] r_valid;
   logic [0:c_W-1]    r_data [STAGES];
   logic [STAGES-1:0] w_adv;
   logic [STAGES-1:0] w_up_valid;
   logic [0:c_W-1]    w_up_data [STAGES];

   // Stage k may advance when downstream accepts or any stage at or after k
   // is empty; this is the unrolled form of the per-stage ready chain.
   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_link
         assign w_adv[k] = i_ready | ~(&r_valid[STAGES-1:k]);
         if (k == 0) begin : g_head
            assign w_up_valid[k] = i_valid;
            assign w_up_data[k]  = w_shifted;
         end else begin : g_body
            assign w_up_valid[k] = r_valid[k-1];
            assign w_up_data[k]  = r_data[k-1];
         end
      end
   endgenerate

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_adv[k]) begin
               r_valid[k] <= w_up_valid[k];
               if (w_up_valid[k]) begin
                  r_data[k] <= w_up_data[k];
               end
            end
         end
      end
   end

`ifdef SHIFT_ROWS_PIPE_TAG_EN
   logic [TAG_W-1:0] r_tag [STAGES];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_adv[k] && w_up_valid[k]) begin
               r_tag[k] <= (k == 0) ? i_tag : r_tag[(k == 0) ? 0 : k - 1];
            end
         end
      end
   end

   assign o_tag = r_tag[STAGES-1];
`endif

   assign o_ready = w_adv[0];
   assign o_valid = r_valid[STAGES-1];
   assign o_data  = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rows_pipe
// Purpose  : Self-checking bench for shift_rows_pipe across NB/STAGES configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;

   localparam int NBV [4] = '{4, 8, 4, 6};
   localparam int STV [4] = '{1, 2, 3, 4};

   logic       clk;
   logic       rstn [4];
   logic       vin  [4];
   logic       rdy  [4];
   logic       inv  [4];
   logic [0:255] din [4];
   logic [7:0] tin  [4];
   logic       ordy [4];
   logic       ov   [4];
   logic [0:255] dout [4];

   logic         w_ordy0, w_ordy1, w_ordy2, w_ordy3;
   logic         w_ov0, w_ov1, w_ov2, w_ov3;
   logic [0:127] w_od0;
   logic [0:255] w_od1;
   logic [0:127] w_od2;
   logic [0:191] w_od3;

`ifdef SHIFT_ROWS_PIPE_TAG_EN
   logic [7:0] tout [4];
   logic [7:0] w_ot0, w_ot1, w_ot2, w_ot3;
   assign tout[0] = w_ot0;
   assign tout[1] = w_ot1;
   assign tout[2] = w_ot2;
   assign tout[3] = w_ot3;
`endif

   shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(8)) u_dut0 (
      .i_clock(clk), .i_reset_n(rstn[0]), .i_valid(vin[0]), .o_ready(w_ordy0),
      .i_inverse(inv[0]), .i_data(din[0][0:127]), .o_valid(w_ov0),
      .i_ready(rdy[0]), .o_data(w_od0)
`ifdef SHIFT_ROWS_PIPE_TAG_EN
      , .i_tag(tin[0]), .o_tag(w_ot0)
`endif
   );

   shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(8)) u_dut1 (
      .i_clock(clk), .i_reset_n(rstn[1]), .i_valid(vin[1]), .o_ready(w_ordy1),
      .i_inverse(inv[1]), .i_data(din[1][0:255]), .o_valid(w_ov1),
      .i_ready(rdy[1]), .o_data(w_od1)
`ifdef SHIFT_ROWS_PIPE_TAG_EN
      , .i_tag(tin[1]), .o_tag(w_ot1)
`endif
   );

   shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(8)) u_dut2 (
      .i_clock(clk), .i_reset_n(rstn[2]), .i_valid(vin[2]), .o_ready(w_ordy2),
      .i_inverse(inv[2]), .i_data(din[2][0:127]), .o_valid(w_ov2),
      .i_ready(rdy[2]), .o_data(w_od2)
`ifdef SHIFT_ROWS_PIPE_TAG_EN
      , .i_tag(tin[2]), .o_tag(w_ot2)
`endif
   );

   shift_rows_pipe #(.NB(6), .STAGES(4), .TAG_W(8)) u_dut3 (
      .i_clock(clk), .i_reset_n(rstn[3]), .i_valid(vin[3]), .o_ready(w_ordy3),
      .i_inverse(inv[3]), .i_data(din[3][0:191]), .o_valid(w_ov3),
      .i_ready(rdy[3]), .o_data(w_od3)
`ifdef SHIFT_ROWS_PIPE_TAG_EN
      , .i_tag(tin[3]), .o_tag(w_ot3)
`endif
   );

   assign ordy[0] = w_ordy0;
   assign ordy[1] = w_ordy1;
   assign ordy[2] = w_ordy2;
   assign ordy[3] = w_ordy3;
   assign ov[0]   = w_ov0;
   assign ov[1]   = w_ov1;
   assign ov[2]   = w_ov2;
   assign ov[3]   = w_ov3;
   assign dout[0] = {w_od0, 128'h0};
   assign dout[1] = w_od1;
   assign dout[2] = {w_od2, 128'h0};
   assign dout[3] = {w_od3, 64'h0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [0:255] act, input logic [0:255] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: rotate each row of the column-major byte matrix.
   function automatic logic [0:255] model(input int nb, input bit inverse, input logic [0:255] x);
      logic [0:255] y;
      int offs8 [4];
      int s, src;
      offs8 = '{0, 1, 3, 4};
      y = '0;
      for (int c = 0; c < nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            s   = (nb == 8) ? offs8[r] : r;
            src = inverse ? (c - s + nb) % nb : (c + s) % nb;
            y[8*(4*c+r) +: 8] = x[8*(4*src+r) +: 8];
         end
      end
      return y;
   endfunction

   function automatic logic [0:255] ramp(input int n);
      logic [0:255] x;
      x = '0;
      for (int k = 0; k < n; k++) x[8*k +: 8] = 8'(k);
      return x;
   endfunction

   function automatic logic [0:255] rand256();
      logic [0:255] x;
      for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
      return x;
   endfunction

   task automatic single_beat(input int d, input bit inverse, input logic [0:255] data,
                              input logic [0:255] exp, input string name);
      int lat;
      @(negedge clk);
      rdy[d] = 1'b1; vin[d] = 1'b1; inv[d] = inverse; din[d] = data; tin[d] = 8'hA5;
      #1;
      chk({name, " ready"}, ordy[d], 1'b1);
      @(negedge clk);
      vin[d] = 1'b0;
      lat = 1;
      #1;
      while (!ov[d] && lat < 10) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk({name, " latency"}, lat, STV[d]);
      chk({name, " data"}, dout[d], exp);
`ifdef SHIFT_ROWS_PIPE_TAG_EN
      chk({name, " tag"}, tout[d], 8'hA5);
`endif
   endtask

   typedef struct {
      logic [0:255] data;
      logic [7:0]   tag;
   } beat_t;

   // Cycle loop: drive (hold until accepted), predict ready, score outputs in order.
   task automatic run_traffic(input int d, input int nbeats, input bit directed,
                              output int first_out, output int last_out);
      beat_t q[$];
      beat_t b;
      int sent, got, cyc;
      bit pend, prev_stall;
      logic [0:255] prev_data;
      logic [7:0] prev_tag;
      sent = 0; got = 0; cyc = 0; pend = 0; prev_stall = 0;
      prev_data = '0; prev_tag = '0;
      first_out = -1; last_out = -1;
      while (got < nbeats && cyc < 3000) begin
         @(negedge clk);
         rdy[d] = directed ? !(cyc >= 4 && cyc <= 7) : ($urandom_range(0, 3) != 0);
         if (!pend && sent < nbeats && (directed || $urandom_range(0, 2) != 0)) begin
            pend   = 1'b1;
            din[d] = rand256();
            inv[d] = directed ? 1'(sent % 2) : 1'($urandom_range(0, 1));
            tin[d] = directed ? 8'(8'h10 + sent) : 8'($urandom);
         end
         vin[d] = pend;
         #1;
         chk("ready", ordy[d], (q.size() < STV[d]) || rdy[d]);
         if (prev_stall) begin
            chk("stall valid", ov[d], 1'b1);
            chk("stall data", dout[d], prev_data);
`ifdef SHIFT_ROWS_PIPE_TAG_EN
            chk("stall tag", tout[d], prev_tag);
`endif
         end
         if (ov[d]) begin
            if (q.size() == 0) begin
               chk("spurious valid", ov[d], 1'b0);
            end else begin
               chk("out data", dout[d], q[0].data);
`ifdef SHIFT_ROWS_PIPE_TAG_EN
               chk("out tag", tout[d], q[0].tag);
`endif
            end
         end
         prev_stall = ov[d] && !rdy[d];
         prev_data  = dout[d];
`ifdef SHIFT_ROWS_PIPE_TAG_EN
         prev_tag   = tout[d];
`endif
         if (ov[d] && rdy[d] && q.size() > 0) begin
            void'(q.pop_front());
            got++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
         if (vin[d] && ordy[d]) begin
            b.data = model(NBV[d], inv[d], din[d]);
            b.tag  = tin[d];
            q.push_back(b);
            sent++;
            pend = 1'b0;
         end
         cyc++;
      end
      chk("traffic beats delivered", got, nbeats);
      @(negedge clk);
      vin[d] = 1'b0;
      rdy[d] = 1'b1;
   endtask

   typedef struct {
      int           d;
      bit           inverse;
      logic [0:255] din;
      logic [0:255] exp;
      string        name;
   } vec_t;

   vec_t vt [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_o, last_o;

      vt[0] = '{0, 1'b0, ramp(16), {128'h00050a0f04090e03080d02070c01060b, 128'h0}, "nb4_fwd"};
      vt[1] = '{0, 1'b1, ramp(16), {128'h000d0a0704010e0b0805020f0c090603, 128'h0}, "nb4_inv"};
      vt[2] = '{0, 1'b1, {128'h00050a0f04090e03080d02070c01060b, 128'h0}, ramp(16), "nb4_roundtrip"};
      vt[3] = '{1, 1'b0, ramp(32),
                256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f, "nb8_fwd"};
      vt[4] = '{1, 1'b1, ramp(32),
                256'h001d1613_04011a17_08051e1b_0c09021f_100d0603_14110a07_18150e0b_1c19120f, "nb8_inv"};
      vt[5] = '{3, 1'b0, ramp(24),
                {192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b, 64'h0}, "nb6_fwd"};

      for (int d = 0; d < 4; d++) begin
         rstn[d] = 1'b0; vin[d] = 1'b0; rdy[d] = 1'b0; inv[d] = 1'b0;
         din[d] = '0; tin[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 4; d++) rstn[d] = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) begin
         chk("reset o_valid", ov[d], 1'b0);
         chk("reset o_data", dout[d], '0);
         chk("reset o_ready", ordy[d], 1'b1);
`ifdef SHIFT_ROWS_PIPE_TAG_EN
         chk("reset o_tag", tout[d], 8'h00);
`endif
      end

      for (int i = 0; i < 6; i++) begin
         single_beat(vt[i].d, vt[i].inverse, vt[i].din, vt[i].exp, vt[i].name);
      end

      // Stall scenario: 10 continuous beats, downstream stalled for cycles 4..7.
      run_traffic(2, 10, 1'b1, first_o, last_o);
      chk("stall first output cycle", first_o, 3);
      chk("stall output span", last_o - first_o, 13);

      // Reset with two beats in flight on the 2-stage pipe.
      @(negedge clk);
      rdy[1] = 1'b1; vin[1] = 1'b1; inv[1] = 1'b0; din[1] = rand256(); tin[1] = 8'h31;
      @(negedge clk);
      din[1] = rand256(); tin[1] = 8'h32;
      @(negedge clk);
      vin[1] = 1'b0; rdy[1] = 1'b0;
      #1;
      chk("pre-reset o_valid", ov[1], 1'b1);
      #2;
      rstn[1] = 1'b0;
      #1;
      chk("async reset o_valid", ov[1], 1'b0);
      chk("async reset o_data", dout[1], '0);
`ifdef SHIFT_ROWS_PIPE_TAG_EN
      chk("async reset o_tag", tout[1], 8'h00);
`endif
      @(negedge clk);
      rstn[1] = 1'b1;
      rdy[1]  = 1'b1;
      #1;
      chk("post-reset o_ready", ordy[1], 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("post-reset no stale beat", ov[1], 1'b0);
      end
      single_beat(1, 1'b1, ramp(32), model(8, 1'b1, ramp(32)), "post_reset_beat");

      for (int d = 0; d < 4; d++) begin
         run_traffic(d, 80, 1'b0, first_o, last_o);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, handshaked successor to the fixed 128-bit ShiftRows stage. Supports all Rijndael block widths (Nb = 4, 6, 8 columns), forward (ShiftRows) or inverse (InvShiftRows) selected per beat, and a configurable register pipeline with valid/ready backpressure.
- Sits between SubBytes and MixColumns in the round datapath.
- Also serves the decrypt path with mode = inverse.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8. Data width W = 32*NB.
- STAGES, 1, register stages between input and output; legal 1..4. Latency = STAGES cycles when unstalled.
- TAG_W, 8, width of the sideband tag. Used only with SHIFT_ROWS_PIPE_TAG_EN.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat this cycle.
- i_inverse  in  1  0 = ShiftRows, 1 = InvShiftRows. Sampled with the beat.
- i_data  in  [0:W-1]  input state.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_data  out  [0:W-1]  shifted state.
- i_tag  in  TAG_W  sideband tag. Present only with the macro.
- o_tag  out  TAG_W  tag aligned with o_data. Present only with the macro.

Behaviour:
- Byte layout: state byte (r,c), with r in 0..3 and c in 0..NB-1, occupies i_data[8*(4c+r) : 8*(4c+r)+7]. This is column-major, and byte 0 is the MSB.
- Row offsets s(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out(r,c) = in(r, (c + s(r)) mod NB).
- Inverse: out(r,c) = in(r, (c - s(r)) mod NB).
- The transform is purely combinational and is applied before stage 0. Later stages only delay the data.
- Each stage k holds a valid bit v[k], data and (with the macro) a tag.
  - adv[STAGES-1] = i_ready | ~v[STAGES-1].
  - adv[k] = adv[k+1] | ~v[k].
  - o_ready = adv[0]. This is a combinational ready chain.
- Stage k loads when adv[k] is high:
  - v[k] <= upstream valid (i_valid for k = 0, v[k-1] for k > 0).
  - Data and tag are loaded only when the upstream valid is high. Otherwise they hold.
- Input transfer occurs when i_valid & o_ready. Output transfer occurs when o_valid & i_ready.
- o_valid = v[STAGES-1]. o_data and o_tag are driven from the last stage.
- Stall: while o_valid & ~i_ready, o_data, o_tag and o_valid stay stable. Upstream stages keep filling until each holds a beat, then o_ready drops.
  - Max beats in flight = STAGES. No loss, no duplication, order preserved.
- Simultaneous output and input transfers with a full pipe: both occur in the same cycle. Throughput is 1 beat per cycle.
- o_ready may be high while i_valid is low. Data is not loaded in that case.
- i_valid must stay high and i_data / i_inverse / i_tag must stay stable until accepted. The bench checks this; the RTL does not enforce it.
- Reset (asynchronous assert, synchronous-release design assumption):
  - All v[k] = 0, all data = 0, all tags = 0.
  - Therefore o_valid = 0, o_data = 0, o_tag = 0, and o_ready = 1 once reset is removed.
- Reset mid-operation discards in-flight beats with no partial output.
- An illegal NB or STAGES value stops elaboration via a generate-time error.

Optional Feature:
- Macro: SHIFT_ROWS_PIPE_TAG_EN.
- Defined:
  - i_tag/o_tag ports exist.
  - The tag travels with its beat through every stage, resets to 0, and is held on stall.
- Undefined:
  - Tag ports and registers are absent.
  - Data path behaviour is identical.

Test Plan:
- NB=4, STAGES=1, forward, i_data bytes 00..0f (byte k = k), i_ready=1 -> one cycle later o_valid=1, o_data = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
- NB=4, inverse, i_data bytes 00..0f -> o_data = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03. Feeding the forward result back with inverse restores 00..0f.
- NB=8, forward, bytes 00..1f -> output column 0 = 00 05 0e 13 and column 7 = 1c 01 0a 0f. Check all 32 bytes against the formula.
- STAGES=3, continuous i_valid with beats 1..10 and alternating i_inverse, i_ready low for cycles 4..7:
  - o_ready drops after 3 beats are in flight.
  - o_data stays stable while stalled.
  - All 10 beats exit in order with the correct mode.
  - Throughput returns to 1 beat per cycle.
- With SHIFT_ROWS_PIPE_TAG_EN, tags 0x10..0x19 on the above traffic -> each o_tag matches its beat. A macro-off build passes the same data checks.
- Assert i_reset_n=0 with 2 beats in flight (STAGES=2) -> same cycle o_valid=0, o_data=0. After release: o_ready=1, no stale beat emitted, and the next beat has latency 2.
